// File: rtl/lab4_net_router_pkg.sv
// Shared types and helpers for the ring-router control slice: port ids,
// output-allocator state encoding and the ring route function.
package lab4_net_router_pkg;

  localparam logic [1:0] PORT_W = 2'd0;
  localparam logic [1:0] PORT_T = 2'd1;
  localparam logic [1:0] PORT_E = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } out_state_e;

  // Shortest-way routing on the ring; an exact half-ring tie is split by id parity.
  function automatic logic [1:0] route_compute(input int unsigned dest,
                                               input int unsigned id,
                                               input int unsigned n);
    int unsigned d;
    d = (dest + n - id) % n;
    if (d == 0)
      return PORT_T;
    else if (2 * d < n)
      return PORT_E;
    else if (2 * d > n)
      return PORT_W;
    else
      return id[0] ? PORT_E : PORT_W;
  endfunction

endpackage

// File: rtl/lab4_net_router_out_alloc.sv
// Per-output allocator: round-robin arbitration among requesting inputs and a
// wormhole lock that holds the output for one input from head to tail flit.
// Optional stall counter under LAB4_NET_ROUTER_CTRL_PERF_EN.
module lab4_net_router_out_alloc
  import lab4_net_router_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_req,
  input  logic [2:0] i_val,
  input  logic [2:0] i_tail,
  input  logic       i_out_rdy,
  output logic       o_out_val,
  output logic [1:0] o_sel
`ifdef LAB4_NET_ROUTER_CTRL_PERF_EN
  ,
  output logic [15:0] o_stall_cnt
`endif
);

  out_state_e      r_state;
  out_state_e      w_state_nxt;
  logic [1:0]      r_owner;
  logic [1:0]      w_owner_nxt;
  logic [1:0]      r_prio;
  logic [1:0]      w_prio_nxt;
  logic [2:0][1:0] w_order;
  logic            w_grant;
  logic [1:0]      w_winner;

  // w_order[0] is the current highest-priority input; scan low to high so the best wins.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = 2'd0;
    case (r_prio)
      2'd1:    w_order = {2'd0, 2'd2, 2'd1};
      2'd2:    w_order = {2'd1, 2'd0, 2'd2};
      default: w_order = {2'd2, 2'd1, 2'd0};
    endcase
    for (int k = 2; k >= 0; k--) begin
      if (i_req[w_order[k]]) begin
        w_grant  = 1'b1;
        w_winner = w_order[k];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    o_out_val   = 1'b0;
    o_sel       = 2'd0;
    case (r_state)
      ST_IDLE: begin
        o_out_val = w_grant;
        o_sel     = w_winner;
        if (w_grant && i_out_rdy) begin
          w_prio_nxt = (w_winner == 2'd2) ? 2'd0 : w_winner + 2'd1;
          if (!i_tail[w_winner]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_winner;
          end
        end
      end
      ST_LOCKED: begin
        o_out_val = i_val[r_owner];
        o_sel     = r_owner;
        if (i_val[r_owner] && i_out_rdy && i_tail[r_owner])
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_prio  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

`ifdef LAB4_NET_ROUTER_CTRL_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= 16'd0;
    else if (o_out_val && !i_out_rdy && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: rtl/lab4_net_router_ctrl_ring.sv
// Ring-router control unit: route computation, per-input packet lock state and
// three output allocators. LAB4_NET_ROUTER_CTRL_PERF_EN adds per-output stall counters.
module lab4_net_router_ctrl_ring
  import lab4_net_router_pkg::*;
#(
  parameter int p_num_routers = 4,
  parameter int p_num_ports   = 3,
  localparam int IW = (p_num_routers > 2) ? $clog2(p_num_routers) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IW-1:0]      router_id,
  input  logic [2:0]         in_val,
  output logic [2:0]         in_rdy,
  input  logic [2:0][IW-1:0] in_dest,
  input  logic [2:0]         in_tail,
  output logic [2:0]         out_val,
  input  logic [2:0]         out_rdy,
  output logic [2:0][1:0]    sel
`ifdef LAB4_NET_ROUTER_CTRL_PERF_EN
  ,
  output logic [2:0][15:0]   stall_cnt
`endif
);

  if (p_num_ports != 3) begin : g_bad_ports
    $error("lab4_net_router_ctrl_ring: p_num_ports must be 3");
  end

  logic [2:0]      r_pkt_busy;
  logic [2:0][1:0] r_route_q;
  logic [2:0][1:0] w_route;
  logic [2:0][2:0] w_req;

  // Body and tail flits follow the route latched from their head flit.
  always_comb begin
    w_route = '0;
    w_req   = '0;
    for (int i = 0; i < 3; i++) begin
      w_route[i] = r_pkt_busy[i] ? r_route_q[i]
                 : route_compute(32'(in_dest[i]), 32'(router_id), p_num_routers);
      for (int o = 0; o < 3; o++)
        w_req[o][i] = in_val[i] && (w_route[i] == 2'(o));
    end
  end

  always_comb begin
    in_rdy = '0;
    for (int i = 0; i < 3; i++)
      in_rdy[i] = in_val[i] && out_rdy[w_route[i]] && (sel[w_route[i]] == 2'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_busy <= '0;
      r_route_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (in_rdy[i]) begin
          r_pkt_busy[i] <= !in_tail[i];
          r_route_q[i]  <= w_route[i];
        end
      end
    end
  end

  for (genvar o = 0; o < 3; o++) begin : g_out
    lab4_net_router_out_alloc u_alloc (
      .clk        (clk),
      .reset      (reset),
      .i_req      (w_req[o]),
      .i_val      (in_val),
      .i_tail     (in_tail),
      .i_out_rdy  (out_rdy[o]),
      .o_out_val  (out_val[o]),
      .o_sel      (sel[o])
`ifdef LAB4_NET_ROUTER_CTRL_PERF_EN
      ,
      .o_stall_cnt(stall_cnt[o])
`endif
    );
  end

  for (genvar i = 0; i < 3; i++) begin : g_dest_chk
    a_dest_legal: assert property (@(posedge clk) disable iff (reset)
      (in_val[i] && !r_pkt_busy[i]) |-> (32'(in_dest[i]) < 32'(p_num_routers)));
  end

endmodule
